// File: rtl/ram_dp_clr_if.sv
// ram_dp_clr_if: bus bundle for the dual-port clearable RAM.
//   Port A: a_re, a_we (per byte lane), a_addr, a_wdata -> a_rdata, a_rvalid
//   Port B: b_re, b_addr -> b_rdata, b_rvalid
//   master: the requester (core, DMA, debug); slave: the RAM.
interface ram_dp_clr_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) ();
  localparam int LANES = DATA_W / 8;

  logic              a_re;
  logic [LANES-1:0]  a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;

  logic              b_re;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;

  modport master (
    output a_re, a_we, a_addr, a_wdata, b_re, b_addr,
    input  a_rdata, a_rvalid, b_rdata, b_rvalid
  );

  modport slave (
    input  a_re, a_we, a_addr, a_wdata, b_re, b_addr,
    output a_rdata, a_rvalid, b_rdata, b_rvalid
  );
endinterface

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: parametrised on-chip RAM with a read/write port A (byte-lane
// write enables, selectable read-during-write), a read-only port B and a
// clear engine that zeroes the array after reset or on request.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous reset, active-high
//   clr   clear request pulse, honoured only while idle
//   busy  high while the clear engine owns the array
//   bus   ram_dp_clr_if.slave: port A and port B signals
//
// Clear FSM
//   state    | meaning
//   ST_IDLE  | array available to ports A and B
//   ST_CLEAR | writing zero to word cnt each clock, ports ignored
module ram_dp_clr #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 8,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  ram_dp_clr_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = DATA_W / 8;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              start_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_old;
  logic [DATA_W-1:0] a_merged;
  logic              a_rd_ok;
  logic              b_rd_ok;

  // start_q carries the auto-clear request across reset release so the
  // sequence kicks off on the first edge after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      start_q <= (CLEAR_ON_RESET != 0);
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_q || clr) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          // cnt parks at the last word; the next clear reloads it to 0
          if (cnt == {ADDR_W{1'b1}}) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array: clear engine has priority; user writes are dropped while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.a_we[i]) begin
          mem[bus.a_addr][8*i +: 8] <= bus.a_wdata[8*i +: 8];
        end
      end
    end
  end

  // Port A old word and the word as it will look after this cycle's write.
  always_comb begin
    a_old    = mem[bus.a_addr];
    a_merged = a_old;
    for (int i = 0; i < LANES; i++) begin
      if (bus.a_we[i]) begin
        a_merged[8*i +: 8] = bus.a_wdata[8*i +: 8];
      end
    end
  end

  assign a_rd_ok = bus.a_re && !busy;
  assign b_rd_ok = bus.b_re && !busy;

  // Port B always sees the pre-write word because the array update above
  // is non-blocking on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.a_rdata  <= '0;
      bus.a_rvalid <= 1'b0;
      bus.b_rdata  <= '0;
      bus.b_rvalid <= 1'b0;
    end else begin
      bus.a_rvalid <= a_rd_ok;
      bus.b_rvalid <= b_rd_ok;
      if (a_rd_ok) begin
        bus.a_rdata <= (RDW_MODE != 0) ? a_merged : a_old;
      end
      if (b_rd_ok) begin
        bus.b_rdata <= mem[bus.b_addr];
      end
    end
  end
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: two ram_dp_clr builds (READ_FIRST and WRITE_FIRST,
// ADDR_W=4, DATA_W=32) driven with identical stimulus. Expected read data is
// pushed to per-port queues when a read is issued and compared when rvalid
// appears.
module tb_ram_dp_clr;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic busy0, busy1;

  ram_dp_clr_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  ram_dp_clr_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  assign bus1.a_re    = bus0.a_re;
  assign bus1.a_we    = bus0.a_we;
  assign bus1.a_addr  = bus0.a_addr;
  assign bus1.a_wdata = bus0.a_wdata;
  assign bus1.b_re    = bus0.b_re;
  assign bus1.b_addr  = bus0.b_addr;

  ram_dp_clr #(.ADDR_W(AW), .DATA_W(DW), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy0), .bus(bus0.slave)
  );
  ram_dp_clr #(.ADDR_W(AW), .DATA_W(DW), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy1), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] qa0[$], qa1[$], qb0[$], qb1[$];
  logic [DW-1:0] last_a0, last_a1, last_b0, last_b1;

  // Advance to the next falling edge and retire any read results.
  task automatic step();
    logic [DW-1:0] e;
    @(negedge clk);
    if (bus0.a_rvalid) begin
      total++;
      if (qa0.size() == 0) begin bad++; $display("FAIL a0_rvalid_unexpected got=1 want=0"); end
      else begin
        e = qa0.pop_front(); last_a0 = e;
        if (bus0.a_rdata !== e) begin bad++; $display("FAIL a0_rdata got=%h want=%h", bus0.a_rdata, e); end
      end
    end
    if (bus1.a_rvalid) begin
      total++;
      if (qa1.size() == 0) begin bad++; $display("FAIL a1_rvalid_unexpected got=1 want=0"); end
      else begin
        e = qa1.pop_front(); last_a1 = e;
        if (bus1.a_rdata !== e) begin bad++; $display("FAIL a1_rdata got=%h want=%h", bus1.a_rdata, e); end
      end
    end
    if (bus0.b_rvalid) begin
      total++;
      if (qb0.size() == 0) begin bad++; $display("FAIL b0_rvalid_unexpected got=1 want=0"); end
      else begin
        e = qb0.pop_front(); last_b0 = e;
        if (bus0.b_rdata !== e) begin bad++; $display("FAIL b0_rdata got=%h want=%h", bus0.b_rdata, e); end
      end
    end
    if (bus1.b_rvalid) begin
      total++;
      if (qb1.size() == 0) begin bad++; $display("FAIL b1_rvalid_unexpected got=1 want=0"); end
      else begin
        e = qb1.pop_front(); last_b1 = e;
        if (bus1.b_rdata !== e) begin bad++; $display("FAIL b1_rdata got=%h want=%h", bus1.b_rdata, e); end
      end
    end
  endtask

  // Drive one cycle of port activity; acc says whether the RAM should accept it.
  task automatic drive(input logic are, input logic [3:0] we, input logic [AW-1:0] aa,
                       input logic [DW-1:0] wd, input logic bre, input logic [AW-1:0] ba,
                       input bit acc);
    logic [DW-1:0] old, mrg;
    bus0.a_re = are; bus0.a_we = we; bus0.a_addr = aa; bus0.a_wdata = wd;
    bus0.b_re = bre; bus0.b_addr = ba;
    if (acc) begin
      old = exp_mem[aa];
      mrg = old;
      for (int i = 0; i < 4; i++) if (we[i]) mrg[8*i +: 8] = wd[8*i +: 8];
      if (are) begin qa0.push_back(old); qa1.push_back(mrg); end
      if (bre) begin qb0.push_back(exp_mem[ba]); qb1.push_back(exp_mem[ba]); end
      exp_mem[aa] = mrg;
    end
    step();
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic model_cleared();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  task automatic test_reset();
    int n0, n1;
    #12;
    total++;
    if ({busy0, busy1, bus0.a_rvalid, bus1.a_rvalid, bus0.b_rvalid, bus1.b_rvalid} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=000000",
        {busy0, busy1, bus0.a_rvalid, bus1.a_rvalid, bus0.b_rvalid, bus1.b_rvalid});
    end
    total++;
    if ((bus0.a_rdata | bus1.a_rdata | bus0.b_rdata | bus1.b_rdata) !== '0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h/%h/%h want=0",
        bus0.a_rdata, bus1.a_rdata, bus0.b_rdata, bus1.b_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (busy0) n0++;
      if (busy1) n1++;
      if (!busy0 && !busy1 && n0 > 0) break;
    end
    total++;
    if (n0 != DEPTH || n1 != DEPTH) begin
      bad++; $display("FAIL autoclear_busy_cycles got=%0d/%0d want=%0d", n0, n1, DEPTH);
    end
    model_cleared();
    for (int a = 0; a < DEPTH; a++)
      drive(1'b1, 4'h0, AW'(a), '0, 1'b1, AW'(DEPTH - 1 - a), 1'b1);
    idle();
  endtask

  task automatic test_byte_lanes();
    drive(1'b0, 4'hF, 4'd2, 32'hAABBCCDD, 1'b0, '0, 1'b1);
    drive(1'b0, 4'b0101, 4'd2, 32'h11223344, 1'b0, '0, 1'b1);
    drive(1'b1, 4'h0, 4'd2, '0, 1'b0, '0, 1'b1);
    total++;
    if (bus0.a_rvalid !== 1'b1 || bus0.a_rdata !== 32'hAA22CC44) begin
      bad++; $display("FAIL lanes_read got=%b/%h want=1/aa22cc44", bus0.a_rvalid, bus0.a_rdata);
    end
    idle();
    total++;
    if (bus0.a_rvalid !== 1'b0) begin
      bad++; $display("FAIL lanes_rvalid_pulse got=%b want=0", bus0.a_rvalid);
    end
  endtask

  task automatic test_rdw();
    drive(1'b0, 4'hF, 4'd5, 32'h12, 1'b0, '0, 1'b1);
    drive(1'b1, 4'hF, 4'd5, 32'h34, 1'b1, 4'd5, 1'b1);
    total++;
    if (bus0.a_rdata !== 32'h12 || bus1.a_rdata !== 32'h34) begin
      bad++; $display("FAIL rdw_a got=%h/%h want=12/34", bus0.a_rdata, bus1.a_rdata);
    end
    total++;
    if (bus0.b_rdata !== 32'h12 || bus1.b_rdata !== 32'h12) begin
      bad++; $display("FAIL rdw_b got=%h/%h want=12/12", bus0.b_rdata, bus1.b_rdata);
    end
    drive(1'b1, 4'h0, 4'd5, '0, 1'b0, '0, 1'b1);
    total++;
    if (bus0.a_rdata !== 32'h34 || bus1.a_rdata !== 32'h34) begin
      bad++; $display("FAIL rdw_after got=%h/%h want=34/34", bus0.a_rdata, bus1.a_rdata);
    end
    drive(1'b0, 4'hF, 4'd6, 32'h11223344, 1'b0, '0, 1'b1);
    drive(1'b1, 4'b0010, 4'd6, 32'hFFFFAAFF, 1'b1, 4'd6, 1'b1);
    total++;
    if (bus1.a_rdata !== 32'h1122AA44 || bus0.a_rdata !== 32'h11223344) begin
      bad++; $display("FAIL rdw_partial got=%h/%h want=11223344/1122aa44", bus0.a_rdata, bus1.a_rdata);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] we;
    for (int k = 0; k < 60; k++) begin
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), we, AW'($urandom_range(0, DEPTH - 1)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), 1'b1);
    end
    idle();
  endtask

  task automatic test_clear_access();
    int n;
    drive(1'b0, 4'hF, 4'd3, 32'hCAFEF00D, 1'b0, '0, 1'b1);
    drive(1'b1, 4'h0, 4'd3, '0, 1'b1, 4'd3, 1'b1);
    idle();
    clr = 1'b1;
    idle();
    clr = 1'b0;
    n = busy0 ? 1 : 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'hF, 4'd3, 32'hFF, 1'b1, 4'd3, 1'b0);
      if (busy0) n++;
      total++;
      if ({bus0.a_rvalid, bus1.a_rvalid, bus0.b_rvalid, bus1.b_rvalid} !== 4'b0) begin
        bad++; $display("FAIL busy_rvalid got=%b want=0000",
          {bus0.a_rvalid, bus1.a_rvalid, bus0.b_rvalid, bus1.b_rvalid});
      end
      total++;
      if (bus0.a_rdata !== 32'hCAFEF00D || bus1.b_rdata !== 32'hCAFEF00D) begin
        bad++; $display("FAIL busy_rdata_hold got=%h/%h want=cafef00d", bus0.a_rdata, bus1.b_rdata);
      end
    end
    for (int k = 0; k < 40; k++) begin
      if (!busy0) break;
      idle();
      if (busy0) n++;
    end
    total++;
    if (n != DEPTH) begin bad++; $display("FAIL clr_busy_cycles got=%0d want=%0d", n, DEPTH); end
    model_cleared();
    drive(1'b1, 4'h0, 4'd3, '0, 1'b1, 4'd3, 1'b1);
    total++;
    if (bus0.a_rdata !== 32'h0 || bus0.b_rdata !== 32'h0) begin
      bad++; $display("FAIL clr_mem3 got=%h/%h want=0", bus0.a_rdata, bus0.b_rdata);
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    drive(1'b0, 4'hF, 4'd15, 32'h5A5A5A5A, 1'b0, '0, 1'b1);
    drive(1'b0, 4'hF, 4'd1, 32'hDEADBEEF, 1'b0, '0, 1'b1);
    drive(1'b1, 4'h0, 4'd1, '0, 1'b1, 4'd1, 1'b1);
    idle();
    clr = 1'b1;
    idle();
    clr = 1'b0;
    for (int k = 0; k < 6; k++) idle();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL midclr_busy got=%b/%b want=0/0", busy0, busy1);
    end
    total++;
    if ((bus0.a_rdata | bus1.a_rdata | bus0.b_rdata | bus1.b_rdata) !== '0) begin
      bad++; $display("FAIL midclr_rdata got=%h/%h/%h/%h want=0",
        bus0.a_rdata, bus1.a_rdata, bus0.b_rdata, bus1.b_rdata);
    end
    qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
    last_a0 = '0; last_a1 = '0; last_b0 = '0; last_b1 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (busy0) n++;
      clr = (n == 5);
      if (!busy0 && n > 0) break;
    end
    clr = 1'b0;
    total++;
    if (n != DEPTH) begin bad++; $display("FAIL restart_busy_cycles got=%0d want=%0d", n, DEPTH); end
    model_cleared();
    drive(1'b1, 4'h0, 4'd15, '0, 1'b1, 4'd1, 1'b1);
    total++;
    if (bus0.a_rdata !== 32'h0 || bus1.b_rdata !== 32'h0) begin
      bad++; $display("FAIL restart_cleared got=%h/%h want=0", bus0.a_rdata, bus1.b_rdata);
    end
    drive(1'b1, 4'h0, 4'd0, '0, 1'b1, 4'd9, 1'b1);
    idle();
  endtask

  initial begin
    bus0.a_re = 1'b0; bus0.a_we = '0; bus0.a_addr = '0; bus0.a_wdata = '0;
    bus0.b_re = 1'b0; bus0.b_addr = '0;
    last_a0 = '0; last_a1 = '0; last_b0 = '0; last_b1 = '0;
    test_reset();
    test_byte_lanes();
    test_rdw();
    test_back_to_back();
    test_clear_access();
    test_reset_mid_clear();
    idle();
    idle();
    total++;
    if (qa0.size() + qa1.size() + qb0.size() + qb1.size() != 0) begin
      bad++; $display("FAIL missing_rvalid got=%0d pending want=0",
        qa0.size() + qa1.size() + qb0.size() + qb1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
